// File: rtl/bg_cfg_arbiter.sv
// Background-manager configuration arbiter.
// Two requesters compete round-robin for a single AXI4-Lite write master.
// At most one write is outstanding: grant in IDLE, drive AW/W in ADDR_DATA,
// wait for the write response in RESP. Any non-OKAY response raises a sticky
// error flag that software clears with err_clr.
module bg_cfg_arbiter #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            req0_valid,
  output logic                            req0_ready,
  input  logic [1:0]                      req0_idx,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   req0_data,
  input  logic                            req1_valid,
  output logic                            req1_ready,
  input  logic [1:0]                      req1_idx,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   req1_data,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic                            busy,
  output logic                            grant_id,
  output logic                            err_flag,
  input  logic                            err_clr
);

  localparam int C_STRB_WIDTH = C_M_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR_DATA,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                          r_ptr;
  logic                          r_grant_id;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [C_M_AXI_DATA_WIDTH-1:0] r_wdata;
  logic                          r_awvalid;
  logic                          r_wvalid;
  logic                          r_aw_done;
  logic                          r_w_done;
  logic                          r_err;

  logic                          w_idle;
  logic                          w_gnt0;
  logic                          w_gnt1;
  logic                          w_grant;
  logic [1:0]                    w_sel_idx;
  logic [C_M_AXI_DATA_WIDTH-1:0] w_sel_data;
  logic                          w_aw_hs;
  logic                          w_w_hs;
  logic                          w_aw_done;
  logic                          w_w_done;
  logic                          w_b_hs;
  logic                          w_bready;
  logic                          w_busy;

  // Round-robin: with both requesting, the pointer picks; a lone requester always wins.
  assign w_idle     = (r_state == S_IDLE);
  assign w_gnt0     = w_idle & req0_valid & (~req1_valid | ~r_ptr);
  assign w_gnt1     = w_idle & req1_valid & (~req0_valid |  r_ptr);
  assign w_grant    = w_gnt0 | w_gnt1;
  assign w_sel_idx  = w_gnt1 ? req1_idx  : req0_idx;
  assign w_sel_data = w_gnt1 ? req1_data : req0_data;

  // A channel counts as done if it finished earlier or is finishing this cycle.
  assign w_aw_hs   = r_awvalid & M_AXI_AWREADY;
  assign w_w_hs    = r_wvalid & M_AXI_WREADY;
  assign w_aw_done = r_aw_done | w_aw_hs;
  assign w_w_done  = r_w_done | w_w_hs;
  assign w_b_hs    = (r_state == S_RESP) & M_AXI_BVALID;

  // Ready is gated by reset because the state reads IDLE while reset is held.
  assign req0_ready    = w_gnt0 & ~ARESET;
  assign req1_ready    = w_gnt1 & ~ARESET;
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = {C_STRB_WIDTH{r_wvalid}};
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = w_bready;
  assign busy          = w_busy;
  assign grant_id      = r_grant_id;
  assign err_flag      = r_err;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_next   = r_state;
    w_bready = 1'b0;
    w_busy   = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_grant) begin
          w_next = S_ADDR_DATA;
        end
      end
      S_ADDR_DATA: begin
        if (w_aw_done && w_w_done) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        w_bready = 1'b1;
        if (M_AXI_BVALID) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
        w_busy = 1'b0;
      end
    endcase
  end

  // Grant capture, pointer update and independent AW/W valid tracking.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_ptr      <= 1'b0;
      r_grant_id <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else if (w_grant) begin
      r_ptr      <= w_gnt0;
      r_grant_id <= w_gnt1;
      r_awaddr   <= C_BASE_ADDR + {{(C_M_AXI_ADDR_WIDTH-4){1'b0}}, w_sel_idx, 2'b00};
      r_wdata    <= w_sel_data;
      r_awvalid  <= 1'b1;
      r_wvalid   <= 1'b1;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_awvalid <= 1'b0;
        r_aw_done <= 1'b1;
      end
      if (w_w_hs) begin
        r_wvalid <= 1'b0;
        r_w_done <= 1'b1;
      end
    end
  end

  // Sticky error flag; a new error wins over a simultaneous clear.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_err <= 1'b0;
    end else if (w_b_hs && (M_AXI_BRESP != 2'b00)) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bg_cfg_arbiter.sv
// Directed bench for bg_cfg_arbiter: a base-0 instance is fully checked and a
// second instance with base 0xFFFF_FFFC shares all inputs to show address wrap.
module tb_bg_cfg_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        req0_valid, req1_valid;
  logic [1:0]  req0_idx, req1_idx;
  logic [31:0] req0_data, req1_data;
  logic        M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, err_clr;
  logic [1:0]  M_AXI_BRESP;

  logic        req0_ready, req1_ready, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY;
  logic        busy, grant_id, err_flag;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA;
  logic [2:0]  M_AXI_AWPROT;
  logic [3:0]  M_AXI_WSTRB;

  logic        wrReq0Ready, wrReq1Ready, wrAwValid, wrWValid, wrBReady;
  logic        wrBusy, wrGrantId, wrErrFlag;
  logic [31:0] wrAwAddr, wrWData;
  logic [2:0]  wrAwProt;
  logic [3:0]  wrWStrb;

  int totalChecks = 0;
  int badChecks   = 0;

  bg_cfg_arbiter dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_idx(req0_idx), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_idx(req1_idx), .req1_data(req1_data),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .busy(busy), .grant_id(grant_id),
    .err_flag(err_flag), .err_clr(err_clr)
  );

  bg_cfg_arbiter #(.C_BASE_ADDR(32'hFFFF_FFFC)) dutWrap (
    .ACLK(ACLK), .ARESET(ARESET),
    .req0_valid(req0_valid), .req0_ready(wrReq0Ready), .req0_idx(req0_idx), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(wrReq1Ready), .req1_idx(req1_idx), .req1_data(req1_data),
    .M_AXI_AWADDR(wrAwAddr), .M_AXI_AWPROT(wrAwProt), .M_AXI_AWVALID(wrAwValid),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(wrWData), .M_AXI_WSTRB(wrWStrb),
    .M_AXI_WVALID(wrWValid), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(wrBReady), .busy(wrBusy), .grant_id(wrGrantId),
    .err_flag(wrErrFlag), .err_clr(err_clr)
  );

  // Free-running 100 MHz clock.
  always #5 ACLK = ~ACLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Every output of both instances must read zero.
  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctl"}, {24'd0, req0_ready, req1_ready, M_AXI_AWVALID, M_AXI_WVALID,
                                M_AXI_BREADY, busy, grant_id, err_flag}, 32'd0);
    checkOutput({tag, "_awaddr"}, M_AXI_AWADDR, 32'd0);
    checkOutput({tag, "_wdata"}, M_AXI_WDATA, 32'd0);
    checkOutput({tag, "_prot_strb"}, {25'd0, M_AXI_AWPROT, M_AXI_WSTRB}, 32'd0);
    checkOutput({tag, "_wrap_ctl"}, {24'd0, wrReq0Ready, wrReq1Ready, wrAwValid, wrWValid,
                                     wrBReady, wrBusy, wrGrantId, wrErrFlag}, 32'd0);
    checkOutput({tag, "_wrap_awaddr"}, wrAwAddr, 32'd0);
    checkOutput({tag, "_wrap_data"}, wrWData, 32'd0);
    checkOutput({tag, "_wrap_prot_strb"}, {25'd0, wrAwProt, wrWStrb}, 32'd0);
  endtask

  // Present requests in IDLE, check which ready fires (expGnt -1 = none), step one cycle.
  task automatic applyStimulus(input logic v0, input logic [1:0] i0, input logic [31:0] d0,
                               input logic v1, input logic [1:0] i1, input logic [31:0] d1,
                               input int expGnt);
    req0_valid = v0; req0_idx = i0; req0_data = d0;
    req1_valid = v1; req1_idx = i1; req1_data = d1;
    #1;
    checkOutput("req0_ready", {31'd0, req0_ready}, {31'd0, expGnt == 0});
    checkOutput("req1_ready", {31'd0, req1_ready}, {31'd0, expGnt == 1});
    checkOutput("busy_idle", {31'd0, busy}, 32'd0);
    @(negedge ACLK);
  endtask

  // Drive AW/W readiness after the given delays, then one idle RESP cycle, then B.
  task automatic axiPhase(input logic [1:0] idx, input logic [31:0] data, input logic gid,
                          input int awDelay, input int wDelay, input logic [1:0] bresp,
                          input logic clrAtB, input logic expErr);
    logic [31:0] expAddr;
    logic [31:0] expAddrWrap;
    bit awDone = 1'b0;
    bit wDone  = 1'b0;
    int c = 0;
    expAddr     = {28'd0, idx, 2'b00};
    expAddrWrap = 32'hFFFF_FFFC + expAddr;
    while (!(awDone && wDone) && c < 16) begin
      M_AXI_AWREADY = (c == awDelay);
      M_AXI_WREADY  = (c == wDelay);
      #1;
      checkOutput("awvalid", {31'd0, M_AXI_AWVALID}, {31'd0, c <= awDelay});
      checkOutput("wvalid", {31'd0, M_AXI_WVALID}, {31'd0, c <= wDelay});
      checkOutput("bready_early", {31'd0, M_AXI_BREADY}, 32'd0);
      checkOutput("busy_addr", {31'd0, busy}, 32'd1);
      checkOutput("ready_busy", {30'd0, req0_ready, req1_ready}, 32'd0);
      checkOutput("grant_id", {31'd0, grant_id}, {31'd0, gid});
      if (c <= awDelay) begin
        checkOutput("awaddr", M_AXI_AWADDR, expAddr);
        checkOutput("awaddr_wrap", wrAwAddr, expAddrWrap);
        checkOutput("awprot", {29'd0, M_AXI_AWPROT}, 32'd0);
      end
      if (c <= wDelay) begin
        checkOutput("wdata", M_AXI_WDATA, data);
        checkOutput("wstrb", {28'd0, M_AXI_WSTRB}, 32'hF);
      end
      if (c == awDelay) awDone = 1'b1;
      if (c == wDelay) wDone = 1'b1;
      @(negedge ACLK);
      c++;
    end
    checkOutput("hs_timeout", {31'd0, awDone && wDone}, 32'd1);
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY  = 1'b0;
    #1;
    checkOutput("bready", {31'd0, M_AXI_BREADY}, 32'd1);
    checkOutput("valids_resp", {30'd0, M_AXI_AWVALID, M_AXI_WVALID}, 32'd0);
    checkOutput("busy_resp", {31'd0, busy}, 32'd1);
    checkOutput("ready_resp", {30'd0, req0_ready, req1_ready}, 32'd0);
    @(negedge ACLK);
    #1;
    checkOutput("bready_hold", {31'd0, M_AXI_BREADY}, 32'd1);
    M_AXI_BVALID = 1'b1;
    M_AXI_BRESP  = bresp;
    err_clr      = clrAtB;
    @(negedge ACLK);
    M_AXI_BVALID = 1'b0;
    M_AXI_BRESP  = 2'b00;
    err_clr      = 1'b0;
    #1;
    checkOutput("bready_done", {31'd0, M_AXI_BREADY}, 32'd0);
    checkOutput("busy_done", {31'd0, busy}, 32'd0);
    checkOutput("err_flag", {31'd0, err_flag}, {31'd0, expErr});
  endtask

  task automatic singleWrite(input int req, input logic [1:0] idx, input logic [31:0] data,
                             input int awDelay, input int wDelay, input logic [1:0] bresp,
                             input logic clrAtB, input logic expErr);
    if (req == 0) applyStimulus(1'b1, idx, data, 1'b0, 2'd0, 32'd0, 0);
    else          applyStimulus(1'b0, 2'd0, 32'd0, 1'b1, idx, data, 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    axiPhase(idx, data, req[0], awDelay, wDelay, bresp, clrAtB, expErr);
  endtask

  initial begin
    logic        v0, v1, gid;
    logic [1:0]  gIdx;
    logic [31:0] gData;
    int n0, n1;

    ARESET = 1'b1;
    req0_valid = 1'b1; req0_idx = 2'd1; req0_data = 32'h1111_1111;
    req1_valid = 1'b1; req1_idx = 2'd2; req1_data = 32'h2222_2222;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
    M_AXI_BRESP = 2'b00; err_clr = 1'b0;
    #2;
    checkAllZero("reset_t0");
    @(negedge ACLK);
    @(negedge ACLK);
    #1;
    checkAllZero("reset_clk");
    @(negedge ACLK);
    ARESET = 1'b0;

    // Contention: both requesters always valid, four writes each.
    n0 = 0; n1 = 0; v0 = 1'b1; v1 = 1'b1;
    for (int g = 0; g < 8; g++) begin
      applyStimulus(v0, n0[1:0], 32'h1000_0000 + n0, v1, 2'(3 - n1), 32'h2000_0000 + n1, g % 2);
      if (g % 2 == 0) begin
        gIdx = n0[1:0]; gData = 32'h1000_0000 + n0; gid = 1'b0;
        n0++; v0 = (n0 < 4);
      end else begin
        gIdx = 2'(3 - n1); gData = 32'h2000_0000 + n1; gid = 1'b1;
        n1++; v1 = (n1 < 4);
      end
      req0_valid = v0; req0_idx = n0[1:0]; req0_data = 32'h1000_0000 + n0;
      req1_valid = v1; req1_idx = 2'(3 - n1); req1_data = 32'h2000_0000 + n1;
      axiPhase(gIdx, gData, gid, 0, 0, 2'b00, 1'b0, 1'b0);
    end

    // Single write with immediate AW/W ready.
    singleWrite(0, 2'd2, 32'hA5A5_0001, 0, 0, 2'b00, 1'b0, 1'b0);

    // Skewed handshakes in both orders; idx 1 also exercises the wrapping base.
    singleWrite(1, 2'd1, 32'h3333_0001, 1, 4, 2'b00, 1'b0, 1'b0);
    singleWrite(0, 2'd3, 32'h4444_0002, 4, 1, 2'b00, 1'b0, 1'b0);

    // Sticky error: set, held through an OKAY, set wins over clear, clear alone.
    singleWrite(0, 2'd0, 32'h5555_0001, 0, 0, 2'b10, 1'b0, 1'b1);
    singleWrite(1, 2'd2, 32'h5555_0002, 0, 0, 2'b00, 1'b0, 1'b1);
    singleWrite(0, 2'd1, 32'h5555_0003, 0, 0, 2'b10, 1'b1, 1'b1);
    err_clr = 1'b1;
    @(negedge ACLK);
    err_clr = 1'b0;
    #1;
    checkOutput("err_clear", {31'd0, err_flag}, 32'd0);
    singleWrite(0, 2'd3, 32'h5555_0004, 0, 0, 2'b11, 1'b0, 1'b1);

    // Reset while waiting in RESP with BVALID low.
    applyStimulus(1'b0, 2'd0, 32'd0, 1'b1, 2'd2, 32'h6666_0001, 1);
    req1_valid = 1'b0;
    M_AXI_AWREADY = 1'b1;
    M_AXI_WREADY  = 1'b1;
    @(negedge ACLK);
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY  = 1'b0;
    #1;
    checkOutput("pre_reset_bready", {31'd0, M_AXI_BREADY}, 32'd1);
    checkOutput("pre_reset_gid", {31'd0, grant_id}, 32'd1);
    req0_valid = 1'b1;
    #2;
    ARESET = 1'b1;
    #1;
    checkAllZero("reset_resp");
    req0_valid = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);
    @(negedge ACLK);
    #1;
    checkOutput("no_replay", {29'd0, busy, M_AXI_AWVALID, M_AXI_WVALID}, 32'd0);
    singleWrite(1, 2'd3, 32'h7777_0001, 0, 0, 2'b00, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

  // Safety net so a stuck bench still reports.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    badChecks++;
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/bg_cfg_arbiter.md
BG_CFG_ARBITER -- requirements
Module: bg_cfg_arbiter

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, AXI4-Lite address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-003 SHALL have parameter C_BASE_ADDR, default 32'h0000_0000, base address of the background-manager register bank.
REQ-004 SHALL have a single clock and an asynchronous, active-high reset, as in the following two ports.
REQ-005 ACLK  in  1  clock; all logic is on the rising edge.
REQ-006 ARESET  in  1  asynchronous active-high reset.
REQ-007 req0_valid  in  1  requester 0 has a register write pending.
REQ-008 req0_ready  out  1  requester 0 write accepted this cycle.
REQ-009 req0_idx  in  2  requester 0 target register index (0..3).
REQ-010 req0_data  in  32  requester 0 write data.
REQ-011 req1_valid, req1_ready, req1_idx, req1_data SHALL have the same directions, widths and meanings as REQ-007..010, for requester 1.
REQ-012 M_AXI_AWADDR out 32; M_AXI_AWPROT out 3; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1: AXI4-Lite write address channel.
REQ-013 M_AXI_WDATA out 32; M_AXI_WSTRB out 4; M_AXI_WVALID out 1; M_AXI_WREADY in 1: AXI4-Lite write data channel.
REQ-014 M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1: AXI4-Lite write response channel.
REQ-015 busy  out  1  a transaction is in flight (state not IDLE).
REQ-016 grant_id  out  1  index of the most recently granted requester.
REQ-017 err_flag  out  1  sticky flag: a non-OKAY BRESP has been received.
REQ-018 err_clr  in  1  synchronous clear of err_flag.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, ADDR_DATA and RESP.
REQ-020 In IDLE with any reqN_valid high, the block SHALL assert the granted reqN_ready for exactly one cycle, latch idx and data, and move to ADDR_DATA.
REQ-021 Arbitration SHALL be round-robin: a priority pointer resets to 0 and, after each grant, points to the non-granted requester; a lone valid requester is always granted.
REQ-022 No reqN_ready SHALL be asserted outside IDLE, and never both in one cycle.
REQ-023 M_AXI_AWVALID and M_AXI_WVALID SHALL both rise in the cycle after the grant (1-cycle latency).
REQ-024 M_AXI_AWADDR SHALL equal C_BASE_ADDR + {idx,2'b00}, modulo 2^32 (wrap, no error); M_AXI_AWPROT = 3'b000; M_AXI_WSTRB = 4'hF; M_AXI_WDATA = latched data.
REQ-025 AWVALID SHALL fall the cycle after AWREADY is sampled high while AWVALID is high; WVALID independently likewise with WREADY; neither SHALL drop before its handshake.
REQ-026 AW and W SHALL complete in either order or simultaneously; the FSM SHALL enter RESP only once both handshakes are done.
REQ-027 In RESP, M_AXI_BREADY SHALL be high; when BVALID is sampled high, the FSM SHALL return to IDLE next cycle and BREADY SHALL fall.
REQ-028 The earliest next grant SHALL be the cycle after the B handshake (one outstanding transaction max).
REQ-029 BRESP != 2'b00 at a B handshake SHALL set err_flag; err_clr clears it; simultaneous set and clear SHALL leave it set.
REQ-030 AW/W address, data and prot outputs SHALL remain stable from VALID rise to handshake.
REQ-031 busy SHALL be high in ADDR_DATA and RESP and low in IDLE.

Reset
REQ-032 While ARESET is high, all outputs SHALL be 0, the FSM SHALL be IDLE and the priority pointer SHALL be 0, independent of ACLK.
REQ-033 A reset asserted mid-transaction SHALL abandon it with no resumption and no replay after release.
REQ-034 The first grant SHALL be possible on the first rising edge after ARESET deasserts.

Verification
REQ-035 Single write: req0 idx=2, data=32'hA5A5_0001, AW/W ready immediately, BRESP=OKAY -> AWADDR=0x08, WDATA=A5A5_0001, req0_ready 1 cycle, busy low after B, err_flag=0.
REQ-036 Contention: req0 and req1 valid continuously with 4 writes each -> grants alternate 0,1,0,1... and all 8 writes appear in order on AW/W.
REQ-037 Skewed handshake: AWREADY 3 cycles before WREADY, then reversed -> each VALID held until its own READY; RESP entered only after both handshakes.
REQ-038 Error: BRESP=2'b10 -> err_flag=1 and held; err_clr together with a second SLVERR -> remains 1; err_clr alone -> 0.
REQ-039 Reset in RESP with BVALID low -> all outputs 0 immediately; after release req1 valid alone is granted and completes normally.
REQ-040 Base wrap: C_BASE_ADDR=32'hFFFF_FFFC, idx=1 -> AWADDR=32'h0000_0000.
